// File: rtl/spi_reg_bank.sv
// rtl/spi_reg_bank.sv - SPI mode-0 peripheral exposing a bank of persistent control registers
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   sclk, cs_n, copi    SPI controller inputs, asynchronous to clk
//   cipo, cipo_oe       registered read data and pad output enable
//   regs_o              flattened register contents, reg k at [k*DATA_W +: DATA_W]
//   wr_strobe, wr_addr  one-clk write pulse and address of the last committed write
//   addr_err            one-clk pulse on a completed frame addressing a missing register
//
// Frame (MSB first): R/W (1 = write), ADDR_W address bits, DATA_W data bits.
module spi_reg_bank #(
    parameter int NUM_REGS    = 5,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sclk,
    input  logic                       cs_n,
    input  logic                       copi,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_o,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       addr_err
);

    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0]  ADDR_LAST  = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0]  FRAME_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, COMMIT, DONE} state_t;

    // Synchronisers; all three inputs share the same depth so copi stays aligned with sclk.
    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, copi_sync;
    logic                   sclk_d, cs_d;
    logic                   sclk_s, cs_s, copi_s;
    logic                   sclk_rise, sclk_fall, cs_fall;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign copi_s    = copi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_s & cs_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            copi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    state_t                     state;
    logic [CNT_W-1:0]           bit_cnt;
    logic [ADDR_W:0]            hdr_sr;    // {rw, addr}; frozen once the data phase starts
    logic [DATA_W-1:0]          data_sr;
    logic [DATA_W-1:0]          out_sr;
    logic [NUM_REGS*DATA_W-1:0] regs_q;
    logic [DATA_W-1:0]          rd_val;
    logic                       hdr_rw;
    logic [ADDR_W-1:0]          hdr_addr;
    logic                       addr_ok;

    assign hdr_rw   = hdr_sr[ADDR_W];
    assign hdr_addr = hdr_sr[ADDR_W-1:0];
    assign addr_ok  = {1'b0, hdr_addr} < NUM_REGS_W;
    assign regs_o   = regs_q;

    // Out-of-range addresses match no register, so reads return zeros.
    always_comb begin
        rd_val = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if ({1'b0, hdr_addr} == (ADDR_W + 1)'(k)) rd_val = regs_q[k*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            hdr_sr    <= '0;
            data_sr   <= '0;
            out_sr    <= '0;
            regs_q    <= '0;
            cipo      <= 1'b0;
            cipo_oe   <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            addr_err  <= 1'b0;
        end else begin
            wr_strobe <= 1'b0;
            addr_err  <= 1'b0;
            case (state)
                IDLE: begin
                    cipo    <= 1'b0;
                    cipo_oe <= 1'b0;
                    if (cs_fall) begin
                        state   <= ADDR;
                        bit_cnt <= '0;
                    end
                end
                ADDR: begin
                    if (cs_s) begin
                        state <= IDLE;
                    end else if (sclk_rise) begin
                        hdr_sr  <= (ADDR_W + 1)'({hdr_sr, copi_s});
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == ADDR_LAST) state <= DATA;
                    end
                end
                DATA: begin
                    if (cs_s) begin
                        state   <= IDLE;
                        cipo    <= 1'b0;
                        cipo_oe <= 1'b0;
                    end else begin
                        if (sclk_rise) begin
                            data_sr <= DATA_W'({data_sr, copi_s});
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == FRAME_LAST) state <= COMMIT;
                        end
                        // Read data: first fall of the data phase loads, later falls shift.
                        if (sclk_fall && !hdr_rw) begin
                            cipo_oe <= 1'b1;
                            if (!cipo_oe) begin
                                cipo   <= rd_val[DATA_W-1];
                                out_sr <= rd_val << 1;
                            end else begin
                                cipo   <= out_sr[DATA_W-1];
                                out_sr <= out_sr << 1;
                            end
                        end
                    end
                end
                COMMIT: begin
                    state   <= DONE;
                    cipo    <= 1'b0;
                    cipo_oe <= 1'b0;
                    if (!addr_ok) begin
                        addr_err <= 1'b1;
                    end else if (hdr_rw) begin
                        wr_strobe <= 1'b1;
                        wr_addr   <= hdr_addr;
                        for (int k = 0; k < NUM_REGS; k++) begin
                            if ({1'b0, hdr_addr} == (ADDR_W + 1)'(k))
                                regs_q[k*DATA_W +: DATA_W] <= data_sr;
                        end
                    end
                end
                DONE: begin
                    cipo    <= 1'b0;
                    cipo_oe <= 1'b0;
                    if (cs_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_reg_bank.sv
// tb/tb_spi_reg_bank.sv - scoreboard bench for spi_reg_bank in default and 16x16 configurations
module tb_spi_reg_bank;

    localparam int NA = 5,  DA = 8,  AA = 7;
    localparam int NB = 16, DB = 16, AB = 4;

    logic clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, copi = 1'b0;
    logic cs_a = 1'b1, cs_b = 1'b1;

    logic              cipo_a, cipo_oe_a, wr_strobe_a, addr_err_a;
    logic [NA*DA-1:0]  regs_a;
    logic [AA-1:0]     wr_addr_a;
    logic              cipo_b, cipo_oe_b, wr_strobe_b, addr_err_b;
    logic [NB*DB-1:0]  regs_b;
    logic [AB-1:0]     wr_addr_b;

    spi_reg_bank #(.NUM_REGS(NA), .DATA_W(DA), .ADDR_W(AA), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_a), .copi(copi),
        .cipo(cipo_a), .cipo_oe(cipo_oe_a), .regs_o(regs_a),
        .wr_strobe(wr_strobe_a), .wr_addr(wr_addr_a), .addr_err(addr_err_a));

    spi_reg_bank #(.NUM_REGS(NB), .DATA_W(DB), .ADDR_W(AB), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_b), .copi(copi),
        .cipo(cipo_b), .cipo_oe(cipo_oe_b), .regs_o(regs_b),
        .wr_strobe(wr_strobe_b), .wr_addr(wr_addr_b), .addr_err(addr_err_b));

    always #5 clk = ~clk;

    int tests = 0, fails = 0;

    logic [31:0] model [2][16];
    int exp_wr_a[$], exp_wr_b[$], exp_err_a[$], exp_err_b[$];
    logic [31:0] exp_rd_a[$], exp_rd_b[$];
    bit oe_seen_a, oe_seen_b;
    logic [31:0] rd_sh_a, rd_sh_b;
    int rd_n_a = 0, rd_n_b = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic int nregs(input int sel); return sel ? NB : NA; endfunction
    function automatic int dw(input int sel);    return sel ? DB : DA; endfunction
    function automatic int aw(input int sel);    return sel ? AB : AA; endfunction

    function automatic logic [255:0] exp_vec(input int sel);
        logic [255:0] v = '0;
        for (int k = 0; k < nregs(sel); k++) v |= 256'(model[sel][k]) << (k * dw(sel));
        return v;
    endfunction

    // Strobe / error monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_strobe_a) begin
                if (exp_wr_a.size() == 0) check("unexpected wr_strobe a", 1, 0);
                else check("wr_addr a", 256'(wr_addr_a), 256'(exp_wr_a.pop_front()));
            end
            if (wr_strobe_b) begin
                if (exp_wr_b.size() == 0) check("unexpected wr_strobe b", 1, 0);
                else check("wr_addr b", 256'(wr_addr_b), 256'(exp_wr_b.pop_front()));
            end
            if (addr_err_a) begin
                if (exp_err_a.size() == 0) check("unexpected addr_err a", 1, 0);
                else begin void'(exp_err_a.pop_front()); tests++; end
            end
            if (addr_err_b) begin
                if (exp_err_b.size() == 0) check("unexpected addr_err b", 1, 0);
                else begin void'(exp_err_b.pop_front()); tests++; end
            end
            if (cipo_oe_a) oe_seen_a = 1'b1;
            if (cipo_oe_b) oe_seen_b = 1'b1;
        end
    end

    // Read-data monitor: samples cipo as a mode-0 controller would, on sclk rise.
    always @(posedge sclk) begin
        if (!cs_a && cipo_oe_a) begin
            if (rd_n_a == 0) rd_sh_a = '0;
            rd_sh_a = {rd_sh_a[30:0], cipo_a};
            rd_n_a++;
            if (rd_n_a == DA) begin
                rd_n_a = 0;
                if (exp_rd_a.size() == 0) check("unexpected read a", 1, 0);
                else check("read data a", 256'(rd_sh_a), 256'(exp_rd_a.pop_front()));
            end
        end
        if (!cs_b && cipo_oe_b) begin
            if (rd_n_b == 0) rd_sh_b = '0;
            rd_sh_b = {rd_sh_b[30:0], cipo_b};
            rd_n_b++;
            if (rd_n_b == DB) begin
                rd_n_b = 0;
                if (exp_rd_b.size() == 0) check("unexpected read b", 1, 0);
                else check("read data b", 256'(rd_sh_b), 256'(exp_rd_b.pop_front()));
            end
        end
    end

    // One SPI transaction of nbits clocks; rst_mid pulses rst_n before cs_n is released.
    task automatic frame(input int sel, input bit wr, input int addr, input int data,
                         input int nbits, input bit rst_mid);
        int fw = 1 + aw(sel) + dw(sel);
        int d  = dw(sel);
        logic [31:0] dmask = (d == 32) ? 32'hFFFF_FFFF : ((32'd1 << d) - 1);
        logic [63:0] f;
        bit complete = (nbits >= fw) && !rst_mid;
        bit exp_oe   = !wr && (nbits >= 1 + aw(sel)) && !rst_mid;
        logic [31:0] dv = 32'(data) & dmask;

        f = (64'(wr) << (fw - 1)) | (64'(addr) << d) | 64'(dv);
        if (complete) begin
            if (addr >= nregs(sel)) begin
                if (sel) exp_err_b.push_back(addr); else exp_err_a.push_back(addr);
                if (!wr) begin if (sel) exp_rd_b.push_back(0); else exp_rd_a.push_back(0); end
            end else if (wr) begin
                if (sel) exp_wr_b.push_back(addr); else exp_wr_a.push_back(addr);
                model[sel][addr] = dv;
            end else begin
                if (sel) exp_rd_b.push_back(model[sel][addr]); else exp_rd_a.push_back(model[sel][addr]);
            end
        end

        oe_seen_a = 1'b0;
        oe_seen_b = 1'b0;
        if (sel) cs_b = 1'b0; else cs_a = 1'b0;
        wait_clks(4);
        for (int i = 0; i < nbits; i++) begin
            copi = (i < fw) ? f[fw-1-i] : 1'($urandom_range(0, 1));
            wait_clks(6);
            sclk = 1'b1;
            wait_clks(6);
            sclk = 1'b0;
        end
        if (rst_mid) begin
            rst_n = 1'b0;
            #1;
            check("async reset regs a", 256'(regs_a), 256'(0));
            check("async reset regs b", 256'(regs_b), 256'(0));
            for (int s = 0; s < 2; s++) for (int k = 0; k < 16; k++) model[s][k] = '0;
            wait_clks(2);
            rst_n = 1'b1;
        end
        wait_clks(6);
        cs_a = 1'b1;
        cs_b = 1'b1;
        wait_clks(6);

        if (sel) begin
            check("pending outputs b", 256'(exp_wr_b.size() + exp_err_b.size() + exp_rd_b.size()), 0);
            check("regs_o b", 256'(regs_b), exp_vec(1));
            check("cipo_oe seen b", 256'(oe_seen_b), 256'(exp_oe));
            check("idle cipo b", 256'({cipo_oe_b, cipo_b}), 0);
        end else begin
            check("pending outputs a", 256'(exp_wr_a.size() + exp_err_a.size() + exp_rd_a.size()), 0);
            check("regs_o a", 256'(regs_a), exp_vec(0));
            check("cipo_oe seen a", 256'(oe_seen_a), 256'(exp_oe));
            check("idle cipo a", 256'({cipo_oe_a, cipo_a}), 0);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        for (int s = 0; s < 2; s++) for (int k = 0; k < 16; k++) model[s][k] = '0;
        rst_n = 1'b0;
        wait_clks(3);
        check("reset regs a", 256'(regs_a), 0);
        check("reset regs b", 256'(regs_b), 0);
        check("reset outputs a", 256'({cipo_a, cipo_oe_a, wr_strobe_a, wr_addr_a, addr_err_a}), 0);
        check("reset outputs b", 256'({cipo_b, cipo_oe_b, wr_strobe_b, wr_addr_b, addr_err_b}), 0);
        rst_n = 1'b1;
        wait_clks(3);

        frame(0, 1, 0, 'hA5, 16, 0);
        frame(0, 1, 4, 'h3C, 16, 0);
        frame(0, 1, 2, 'hFF, 16, 0);
        frame(0, 0, 2, 0, 16, 0);
        frame(0, 1, 5, 'h77, 16, 0);
        frame(0, 1, 1, 'h55, 10, 0);
        frame(0, 1, 1, 'h12, 16, 0);
        frame(0, 1, 3, 'h81, 20, 0);
        frame(0, 0, 4, 0, 16, 0);
        frame(0, 0, 100, 0, 16, 0);
        frame(0, 1, 6, 'h11, 12, 1);
        frame(0, 1, 0, 'h5A, 16, 0);
        frame(0, 0, 0, 0, 16, 0);

        frame(1, 1, 'hF, 'hBEEF, 21, 0);
        frame(1, 1, 3, 'h1234, 21, 0);
        frame(1, 0, 'hF, 0, 21, 0);
        frame(1, 1, 2, 'hAAAA, 15, 1);
        frame(1, 0, 'hF, 0, 21, 0);
        frame(1, 1, 'hF, 'hBEEF, 21, 0);
        frame(1, 0, 'hF, 0, 21, 0);

        repeat (20) begin
            bit wr = 1'($urandom_range(0, 1));
            int nb = 16 + $urandom_range(0, 3);
            if (wr && ($urandom_range(0, 3) == 0)) nb = $urandom_range(2, 15);
            frame(0, wr, $urandom_range(0, 7), $urandom, nb, 0);
        end
        repeat (12) begin
            bit wr = 1'($urandom_range(0, 1));
            int nb = 21 + $urandom_range(0, 2);
            if (wr && ($urandom_range(0, 3) == 0)) nb = $urandom_range(2, 20);
            frame(1, wr, $urandom_range(0, 15), $urandom, nb, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
